// File: rtl/nx_fifo_rd_stream.sv
// Read-side drain engine: pops a show-ahead FIFO into a registered valid/ready stream
// through a 2-entry skid, with BURST_LEN beat framing and a wrapping accepted-beat counter.
module nx_fifo_rd_stream #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] beat_count,
  output logic             busy
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [BW-1:0]    b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic             psh;

  // Pop decision depends only on FIFO state, skid fill and clear, never on out_ready.
  assign fifo_ren   = !rst && !fifo_empty && (occ_q != 2'd2) && !clear;
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = head_q;
  assign out_last   = out_valid && (b_q == B_LAST);
  assign occupancy  = occ_q;
  assign beat_count = cnt_q;
  assign busy       = out_valid || !fifo_empty;

  assign acc = out_valid && out_ready;
  assign psh = fifo_ren;

  // Skid movement, frame index and beat counter next-state.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    b_d    = b_q;
    cnt_d  = cnt_q;

    if (acc) begin
      cnt_d = cnt_q + CNT_W'(1);
      b_d   = (b_q == B_LAST) ? '0 : b_q + BW'(1);
    end

    if (clear) begin
      occ_d  = 2'd0;
      head_d = '0;
      tail_d = '0;
      b_d    = '0;
    end else if (psh && !acc) begin
      if (occ_q == 2'd0) begin
        head_d = fifo_rdata;
      end else begin
        tail_d = fifo_rdata;
      end
      occ_d = occ_q + 2'd1;
    end else if (acc && !psh) begin
      // Head is zeroed when the skid empties so out_data reads 0 while idle.
      head_d = (occ_q == 2'd2) ? tail_q : '0;
      tail_d = '0;
      occ_d  = occ_q - 2'd1;
    end else if (acc && psh) begin
      head_d = fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Scoreboard bench for nx_fifo_rd_stream: a queue-model FIFO feeds two builds
// (BURST_LEN=4/CNT_W=4 and BURST_LEN=1/CNT_W=16) checked against a queue reference.
module tb_nx_fifo_rd_stream;

  localparam int unsigned W  = 8;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          out_ready;

  logic          fifo_ren, out_valid, out_last, busy;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] beat_count;

  logic          fifo_ren_b, out_valid_b, out_last_b, busy_b;
  logic [W-1:0]  out_data_b;
  logic [1:0]    occupancy_b;
  logic [15:0]   beat_count_b;

  logic [W-1:0]  fq[$];
  logic [W-1:0]  exp_q[$];
  int            total_m = 0;
  int            bidx = 0;
  int            errors = 0;
  int            checks = 0;
  logic          ren_s = 1'b0;
  logic [W-1:0]  head_m;
  logic          exp_ren;

  always #5 clk = ~clk;

  nx_fifo_rd_stream #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .occupancy(occupancy), .beat_count(beat_count), .busy(busy));

  nx_fifo_rd_stream #(.WIDTH(W), .BURST_LEN(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .occupancy(occupancy_b), .beat_count(beat_count_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fq[0];
  endtask

  // Advance one cycle; a pop seen before the edge moves the FIFO head into the expected queue.
  task automatic step();
    @(posedge clk);
    #1;
    if (ren_s && fq.size() != 0) exp_q.push_back(fq.pop_front());
    upd_fifo();
  endtask

  task automatic push(input logic [W-1:0] d);
    fq.push_back(d);
    upd_fifo();
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (fq.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    chk({name, "_drained"}, 32'(fq.size() + exp_q.size()), 32'd0);
    chk({name, "_occ0"}, 32'(occupancy), 32'd0);
  endtask

  task automatic wait_occ2(input string name);
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 2'd2) break;
      step();
    end
    chk({name, "_occ2"}, 32'(occupancy), 32'd2);
  endtask

  // Monitor: compares both builds against the reference queue every cycle.
  always @(negedge clk) begin
    ren_s = fifo_ren;
    if (!rst) begin
      head_m  = (exp_q.size() != 0) ? exp_q[0] : '0;
      exp_ren = !fifo_empty && (exp_q.size() < 2) && !clear;
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("out_data", 32'(out_data), 32'(head_m));
      chk("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
      chk("busy", 32'(busy), 32'((exp_q.size() != 0) || !fifo_empty));
      chk("beat_count", 32'(beat_count), 32'(total_m % (1 << CW)));
      chk("b_valid", 32'(out_valid_b), 32'(exp_q.size() != 0));
      chk("b_data", 32'(out_data_b), 32'(head_m));
      chk("b_last", 32'(out_last_b), 32'(exp_q.size() != 0));
      chk("b_ren", 32'(fifo_ren_b), 32'(exp_ren));
      chk("b_beat_count", 32'(beat_count_b), 32'(total_m % 65536));
      if (!out_valid) chk("out_last_idle", 32'(out_last), 32'd0);
      if (out_valid && out_ready) begin
        chk("out_last", 32'(out_last), 32'(bidx == BL - 1));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        total_m++;
        bidx = (bidx + 1) % BL;
      end
      if (clear) begin
        exp_q.delete();
        bidx = 0;
      end
    end
  end

  initial begin
    logic [W-1:0]  first;
    logic [CW-1:0] saved;
    int            ren_run;

    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    upd_fifo();
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_bcnt", 32'(beat_count), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    step();

    // Full-rate drain of 1..8.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    ren_run = 0;
    for (int i = 0; i < 12; i++) begin
      if (fifo_ren) ren_run++;
      step();
    end
    chk("fullrate_ren_cycles", 32'(ren_run), 32'd8);
    drain("fullrate");
    chk("fullrate_bcnt", 32'(beat_count), 32'd8);

    // Backpressure: hold ready low with four words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'($urandom));
    first = fq[0];
    for (int i = 0; i < 5; i++) step();
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_ren", 32'(fifo_ren), 32'd0);
    chk("bp_data", 32'(out_data), 32'(first));
    chk("bp_valid", 32'(out_valid), 32'd1);
    drain("bp");

    // Clear with occupancy=2 at beat index 2.
    for (int i = 0; i < 6; i++) push(W'($urandom));
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      out_ready = (bidx != 2);
      if (bidx == 2 && occupancy == 2'd2) break;
    end
    chk("clr_pre_occ", 32'(occupancy), 32'd2);
    saved = beat_count;
    clear = 1'b1;
    #1;
    chk("clr_ren", 32'(fifo_ren), 32'd0);
    step();
    clear = 1'b0;
    chk("clr_occ", 32'(occupancy), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_bcnt", 32'(beat_count), 32'(saved));
    drain("clr");

    // Asynchronous reset mid-stream with a full skid.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'($urandom));
    wait_occ2("arst");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ren", 32'(fifo_ren), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_bcnt", 32'(beat_count), 32'd0);
    exp_q.delete();
    total_m = 0;
    bidx = 0;
    step();
    rst = 1'b0;
    drain("arst");

    // Counter wrap: 17 accepted beats since the last reset in total on a 4-bit counter.
    for (int i = 0; i < 17 - total_m; i++) push(W'($urandom));
    drain("wrap");
    chk("wrap_bcnt", 32'(beat_count), 32'(17 % 16));
    chk("wrap_bcnt_b", 32'(beat_count_b), 32'd17);

    // Alternating ready with continuous refill, then fully random traffic.
    for (int c = 0; c < 600; c++) begin
      step();
      clear = 1'b0;
      if (c < 80) begin
        if (fq.size() < 8) push(W'($urandom));
        out_ready = (c % 2 == 0);
      end else begin
        if (fq.size() < 8 && $urandom_range(0, 3) != 0) push(W'($urandom));
        out_ready = ($urandom_range(0, 2) != 0);
        clear = ($urandom_range(0, 49) == 0);
      end
    end
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
